// File: rtl/decode_issue_unit_pkg.sv
// Shared types for the decode/issue stage: opcodes, the per-opcode attribute
// table, the control bus handed to execute, and the stage FSM states.
package decode_issue_unit_pkg;

    localparam int OPC_W   = 7;
    localparam int FIELD_W = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 7'h00,
        OP_ADD   = 7'h01,
        OP_ADDI  = 7'h02,
        OP_LOAD  = 7'h03,
        OP_STORE = 7'h04,
        OP_VADD  = 7'h05,
        OP_VLOAD = 7'h06,
        OP_JAL   = 7'h07,
        OP_JALR  = 7'h08,
        OP_BEQ   = 7'h09,
        OP_HALT  = 7'h3F
    } opcode_e;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_e;

    // Decoded control fields offered to execute; unused fields stay zero.
    typedef struct packed {
        opcode_e              op;
        logic                 register_wr_en;
        logic [FIELD_W-1:0]   write_register;
        logic                 write_vector;
        logic                 read1_en;
        logic                 read1_vector;
        logic [FIELD_W-1:0]   read_register1;
        logic                 read2_en;
        logic                 read2_vector;
        logic [FIELD_W-1:0]   read_register2;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic                 store_pc;
        logic                 halt;
    } control_bus;

    // Per-opcode attributes; wr_link redirects the write to the link register.
    typedef struct packed {
        logic defined;
        logic wr;
        logic wr_vec;
        logic wr_link;
        logic rd1;
        logic rd1_vec;
        logic rd2;
        logic rd2_vec;
        logic mem_rd;
        logic mem_wr;
        logic branch;
        logic store_pc;
        logic halt;
    } op_attr_t;

    localparam op_attr_t ATTR_UNDEF = '0;
    localparam op_attr_t ATTR_NOP   = '{defined: 1'b1, default: 1'b0};
    localparam op_attr_t ATTR_ADD   = '{defined: 1'b1, wr: 1'b1, rd1: 1'b1, rd2: 1'b1, default: 1'b0};
    localparam op_attr_t ATTR_ADDI  = '{defined: 1'b1, wr: 1'b1, rd1: 1'b1, default: 1'b0};
    localparam op_attr_t ATTR_LOAD  = '{defined: 1'b1, wr: 1'b1, rd1: 1'b1, mem_rd: 1'b1, default: 1'b0};
    localparam op_attr_t ATTR_STORE = '{defined: 1'b1, rd1: 1'b1, rd2: 1'b1, mem_wr: 1'b1, default: 1'b0};
    localparam op_attr_t ATTR_VADD  = '{defined: 1'b1, wr: 1'b1, wr_vec: 1'b1, rd1: 1'b1, rd1_vec: 1'b1,
                                        rd2: 1'b1, rd2_vec: 1'b1, default: 1'b0};
    localparam op_attr_t ATTR_VLOAD = '{defined: 1'b1, wr: 1'b1, wr_vec: 1'b1, rd1: 1'b1, mem_rd: 1'b1,
                                        default: 1'b0};
    localparam op_attr_t ATTR_JAL   = '{defined: 1'b1, wr: 1'b1, wr_link: 1'b1, store_pc: 1'b1, default: 1'b0};
    localparam op_attr_t ATTR_JALR  = '{defined: 1'b1, wr: 1'b1, wr_link: 1'b1, rd1: 1'b1, store_pc: 1'b1,
                                        default: 1'b0};
    localparam op_attr_t ATTR_BEQ   = '{defined: 1'b1, rd1: 1'b1, rd2: 1'b1, branch: 1'b1, default: 1'b0};
    localparam op_attr_t ATTR_HALT  = '{defined: 1'b1, halt: 1'b1, default: 1'b0};

    // Opcode table lookup; anything not listed is undefined and behaves as nop.
    function automatic op_attr_t op_attr(input logic [OPC_W-1:0] opc);
        op_attr_t a;
        case (opc)
            OP_NOP:   a = ATTR_NOP;
            OP_ADD:   a = ATTR_ADD;
            OP_ADDI:  a = ATTR_ADDI;
            OP_LOAD:  a = ATTR_LOAD;
            OP_STORE: a = ATTR_STORE;
            OP_VADD:  a = ATTR_VADD;
            OP_VLOAD: a = ATTR_VLOAD;
            OP_JAL:   a = ATTR_JAL;
            OP_JALR:  a = ATTR_JALR;
            OP_BEQ:   a = ATTR_BEQ;
            OP_HALT:  a = ATTR_HALT;
            default:  a = ATTR_UNDEF;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/decode_issue_unit_scoreboard.sv
// One pending bit per register of a file: set when a writer issues, cleared
// when its writeback retires. A set and clear of the same register in one
// cycle leaves it pending, because the newer writer is still outstanding.
module issue_scoreboard #(
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        set_en,
    input  logic [$clog2(NUM_REGS)-1:0] set_idx,
    input  logic                        clr_en,
    input  logic [$clog2(NUM_REGS)-1:0] clr_idx,
    output logic [NUM_REGS-1:0]         pending,
    output logic                        pending_next_any
);

    logic [NUM_REGS-1:0] pending_next;

    // Next pending vector: clear first so a same-cycle set overrides it.
    always_comb begin
        pending_next = pending;
        if (clr_en) pending_next[clr_idx] = 1'b0;
        if (set_en) pending_next[set_idx] = 1'b1;
        pending_next_any = |pending_next;
    end

    // Pending register.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_next;
    end

endmodule

// File: rtl/decode_issue_unit.sv
// Decode/issue stage: holds one fetched instruction, decodes it, stalls on
// scoreboard hazards, issues to execute, and drains to a halted state.
module decode_issue_unit
    import decode_issue_unit_pkg::*;
#(
    parameter int INST_W    = 32,
    parameter int PC_W      = 36,
    parameter int NUM_SREGS = 32,
    parameter int NUM_VREGS = 32,
    parameter int LINK_REG  = 31
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [INST_W-1:0]            if_inst,
    input  logic [PC_W-1:0]              if_pc,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output control_bus                   ex_ctrl,
    output logic [PC_W-1:0]              ex_pc,
    input  logic                         wb_s_valid,
    input  logic [$clog2(NUM_SREGS)-1:0] wb_s_idx,
    input  logic                         wb_v_valid,
    input  logic [$clog2(NUM_VREGS)-1:0] wb_v_idx,
    input  logic                         flush,
    output logic                         illegal,
    output logic                         halted
);

    localparam int SIDX_W = $clog2(NUM_SREGS);
    localparam int VIDX_W = $clog2(NUM_VREGS);

    logic              stage_valid;
    logic [INST_W-1:0] inst_q;
    logic [PC_W-1:0]   pc_q;
    state_e            state;
    state_e            state_next;
    op_attr_t          attr;
    control_bus        ctrl;
    logic              hazard;
    logic              issue;
    logic              capture;
    logic [NUM_SREGS-1:0] s_pend;
    logic [NUM_VREGS-1:0] v_pend;
    logic              s_next_any;
    logic              v_next_any;
    logic              s_set;
    logic              v_set;
    logic              unused_bits;

    assign unused_bits = ^inst_q[9:0];

    // Decode the held instruction; fields are only driven when the opcode uses them.
    always_comb begin
        attr = op_attr(inst_q[INST_W-1 -: OPC_W]);
        ctrl = '0;
        if (attr.defined) ctrl.op = opcode_e'(inst_q[INST_W-1 -: OPC_W]);
        ctrl.register_wr_en = attr.wr;
        if (attr.wr) ctrl.write_register = attr.wr_link ? FIELD_W'(LINK_REG) : inst_q[24:20];
        ctrl.write_vector = attr.wr && attr.wr_vec;
        ctrl.read1_en     = attr.rd1;
        ctrl.read1_vector = attr.rd1 && attr.rd1_vec;
        if (attr.rd1) ctrl.read_register1 = inst_q[19:15];
        ctrl.read2_en     = attr.rd2;
        ctrl.read2_vector = attr.rd2 && attr.rd2_vec;
        if (attr.rd2) ctrl.read_register2 = inst_q[14:10];
        ctrl.mem_read  = attr.mem_rd;
        ctrl.mem_write = attr.mem_wr;
        ctrl.branch    = attr.branch;
        ctrl.store_pc  = attr.store_pc;
        ctrl.halt      = attr.halt;
    end

    // Hazard against the registered scoreboard: any read or the write hitting a pending register.
    always_comb begin
        hazard = 1'b0;
        if (ctrl.read1_en)
            hazard = hazard | (ctrl.read1_vector ? v_pend[VIDX_W'(ctrl.read_register1)]
                                                 : s_pend[SIDX_W'(ctrl.read_register1)]);
        if (ctrl.read2_en)
            hazard = hazard | (ctrl.read2_vector ? v_pend[VIDX_W'(ctrl.read_register2)]
                                                 : s_pend[SIDX_W'(ctrl.read_register2)]);
        if (ctrl.register_wr_en)
            hazard = hazard | (ctrl.write_vector ? v_pend[VIDX_W'(ctrl.write_register)]
                                                 : s_pend[SIDX_W'(ctrl.write_register)]);
    end

    // FSM next state plus the handshake outputs that depend on it.
    always_comb begin
        state_next = state;
        ex_valid   = (state == RUN) && stage_valid && !hazard;
        if_ready   = (state == RUN) && (!stage_valid || (ex_valid && ex_ready));
        halted     = (state == HALTED);
        case (state)
            RUN:     if (ex_valid && ex_ready && !flush && ctrl.halt) state_next = DRAIN;
            DRAIN:   if (!s_next_any && !v_next_any) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    assign issue   = ex_valid && ex_ready && !flush;
    assign capture = if_valid && if_ready;
    assign illegal = issue && !attr.defined;
    assign s_set   = issue && ctrl.register_wr_en && !ctrl.write_vector;
    assign v_set   = issue && ctrl.register_wr_en && ctrl.write_vector;
    assign ex_ctrl = ctrl;
    assign ex_pc   = pc_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // Holding register: flush wins over capture and issue, capture refills on issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            inst_q      <= '0;
            pc_q        <= '0;
        end else if (flush) begin
            stage_valid <= 1'b0;
        end else if (capture) begin
            stage_valid <= 1'b1;
            inst_q      <= if_inst;
            pc_q        <= if_pc;
        end else if (issue) begin
            stage_valid <= 1'b0;
        end
    end

    issue_scoreboard #(.NUM_REGS(NUM_SREGS)) u_sb_scalar (
        .clk              (clk),
        .rst              (rst),
        .set_en           (s_set),
        .set_idx          (SIDX_W'(ctrl.write_register)),
        .clr_en           (wb_s_valid),
        .clr_idx          (wb_s_idx),
        .pending          (s_pend),
        .pending_next_any (s_next_any)
    );

    issue_scoreboard #(.NUM_REGS(NUM_VREGS)) u_sb_vector (
        .clk              (clk),
        .rst              (rst),
        .set_en           (v_set),
        .set_idx          (VIDX_W'(ctrl.write_register)),
        .clr_en           (wb_v_valid),
        .clr_idx          (wb_v_idx),
        .pending          (v_pend),
        .pending_next_any (v_next_any)
    );

endmodule

// File: tb/tb_decode_issue_unit.sv
// Directed bench for decode_issue_unit with hand-computed expectations.
module tb_decode_issue_unit;
    import decode_issue_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [35:0] if_pc;
    logic        ex_valid;
    logic        ex_ready;
    control_bus  ex_ctrl;
    logic [35:0] ex_pc;
    logic        wb_s_valid;
    logic [4:0]  wb_s_idx;
    logic        wb_v_valid;
    logic [4:0]  wb_v_idx;
    logic        flush;
    logic        illegal;
    logic        halted;

    int nChecks;
    int nErrors;

    decode_issue_unit dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_ctrl    (ex_ctrl),
        .ex_pc      (ex_pc),
        .wb_s_valid (wb_s_valid),
        .wb_s_idx   (wb_s_idx),
        .wb_v_valid (wb_v_valid),
        .wb_v_idx   (wb_v_idx),
        .flush      (flush),
        .illegal    (illegal),
        .halted     (halted)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2, 10'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [35:0] pc,
                                 input logic rdy, input logic fl,
                                 input logic sv, input logic [4:0] si,
                                 input logic vv, input logic [4:0] vi);
        if_valid   = v;
        if_inst    = inst;
        if_pc      = pc;
        ex_ready   = rdy;
        flush      = fl;
        wb_s_valid = sv;
        wb_s_idx   = si;
        wb_v_valid = vv;
        wb_v_idx   = vi;
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 32'h0, 36'h0, rdy, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wbScalar(input logic [4:0] idx);
        applyStimulus(1'b0, 32'h0, 36'h0, 1'b1, 1'b0, 1'b1, idx, 1'b0, 5'd0);
        tick();
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        rst = 1'b1;
        idle(1'b0);
        tick();
        tick();
        checkOutput("reset ex_valid", 64'(ex_valid), 64'd0);
        checkOutput("reset illegal", 64'(illegal), 64'd0);
        checkOutput("reset halted", 64'(halted), 64'd0);
        checkOutput("reset ex_ctrl", 64'(ex_ctrl), 64'd0);
        checkOutput("reset ex_pc", 64'(ex_pc), 64'd0);
        checkOutput("reset spend", 64'(dut.u_sb_scalar.pending), 64'd0);
        checkOutput("reset state", 64'(dut.state), 64'(RUN));
        rst = 1'b0;

        // Three independent adds stream back to back.
        applyStimulus(1'b1, mk(OP_ADD, 5'd1, 5'd10, 5'd11), 36'h100, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("stream if_ready", 64'(if_ready), 64'd1);
        checkOutput("stream lat0", 64'(ex_valid), 64'd0);
        tick();
        applyStimulus(1'b1, mk(OP_ADD, 5'd2, 5'd12, 5'd13), 36'h104, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("stream ev1", 64'(ex_valid), 64'd1);
        checkOutput("stream pc1", 64'(ex_pc), 64'h100);
        checkOutput("stream wr1", 64'(ex_ctrl.write_register), 64'd1);
        checkOutput("stream wren1", 64'(ex_ctrl.register_wr_en), 64'd1);
        tick();
        applyStimulus(1'b1, mk(OP_ADD, 5'd3, 5'd14, 5'd15), 36'h108, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("stream ev2", 64'(ex_valid), 64'd1);
        checkOutput("stream pc2", 64'(ex_pc), 64'h104);
        tick();
        idle(1'b1);
        checkOutput("stream ev3", 64'(ex_valid), 64'd1);
        checkOutput("stream pc3", 64'(ex_pc), 64'h108);
        tick();
        idle(1'b1);
        checkOutput("stream drained", 64'(ex_valid), 64'd0);
        checkOutput("stream pending", 64'(dut.u_sb_scalar.pending), 64'h0000_000E);
        wbScalar(5'd1);
        wbScalar(5'd2);
        wbScalar(5'd3);
        idle(1'b1);
        checkOutput("stream cleared", 64'(dut.u_sb_scalar.pending), 64'd0);

        // Read-after-write on r5 released one cycle after the writeback.
        applyStimulus(1'b1, mk(OP_ADD, 5'd5, 5'd20, 5'd21), 36'h200, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b1, mk(OP_ADDI, 5'd6, 5'd5, 5'd0), 36'h204, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("raw writer", 64'(ex_valid), 64'd1);
        tick();
        idle(1'b1);
        checkOutput("raw stall a", 64'(ex_valid), 64'd0);
        tick();
        idle(1'b1);
        checkOutput("raw stall b", 64'(ex_valid), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 36'h0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        checkOutput("raw no bypass", 64'(ex_valid), 64'd0);
        tick();
        idle(1'b1);
        checkOutput("raw release", 64'(ex_valid), 64'd1);
        checkOutput("raw pc", 64'(ex_pc), 64'h204);
        tick();
        idle(1'b1);
        checkOutput("raw pending", 64'(dut.u_sb_scalar.pending), 64'h40);

        // Issue writing r7 while r7 retires: set wins.
        applyStimulus(1'b1, mk(OP_ADD, 5'd7, 5'd20, 5'd21), 36'h300, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 36'h0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
        checkOutput("setwin issue", 64'(ex_valid), 64'd1);
        tick();
        idle(1'b1);
        checkOutput("setwin pending", 64'(dut.u_sb_scalar.pending), 64'hC0);
        wbScalar(5'd6);
        wbScalar(5'd7);
        idle(1'b1);
        checkOutput("setwin cleared", 64'(dut.u_sb_scalar.pending), 64'd0);

        // Held instruction is flushed; a flush during issue sets nothing.
        applyStimulus(1'b1, mk(OP_ADD, 5'd8, 5'd20, 5'd21), 36'h400, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b1, mk(OP_ADD, 5'd9, 5'd20, 5'd21), 36'h404, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("hold ev", 64'(ex_valid), 64'd1);
        checkOutput("hold if_ready", 64'(if_ready), 64'd0);
        tick();
        applyStimulus(1'b1, mk(OP_ADD, 5'd9, 5'd20, 5'd21), 36'h404, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("hold stable ev", 64'(ex_valid), 64'd1);
        checkOutput("hold stable pc", 64'(ex_pc), 64'h400);
        tick();
        idle(1'b0);
        checkOutput("flush ev", 64'(ex_valid), 64'd0);
        checkOutput("flush pending", 64'(dut.u_sb_scalar.pending), 64'd0);
        checkOutput("flush if_ready", 64'(if_ready), 64'd1);
        applyStimulus(1'b1, mk(OP_ADD, 5'd9, 5'd20, 5'd21), 36'h404, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 36'h0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("refetch ev", 64'(ex_valid), 64'd1);
        checkOutput("refetch pc", 64'(ex_pc), 64'h404);
        tick();
        idle(1'b1);
        checkOutput("flush issue ev", 64'(ex_valid), 64'd0);
        checkOutput("flush issue pend", 64'(dut.u_sb_scalar.pending), 64'd0);

        // jal writes the link register and stores the pc.
        applyStimulus(1'b1, mk(OP_JAL, 5'd3, 5'd0, 5'd0), 36'h500, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle(1'b1);
        checkOutput("jal wr", 64'(ex_ctrl.write_register), 64'd31);
        checkOutput("jal wren", 64'(ex_ctrl.register_wr_en), 64'd1);
        checkOutput("jal store_pc", 64'(ex_ctrl.store_pc), 64'd1);
        tick();
        idle(1'b1);
        checkOutput("jal pending", 64'(dut.u_sb_scalar.pending), 64'h8000_0000);
        wbScalar(5'd31);

        // Vector writer marks only the vector scoreboard.
        applyStimulus(1'b1, mk(OP_VADD, 5'd2, 5'd3, 5'd4), 36'h600, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle(1'b1);
        checkOutput("vadd ev", 64'(ex_valid), 64'd1);
        checkOutput("vadd vec", 64'(ex_ctrl.write_vector), 64'd1);
        tick();
        idle(1'b1);
        checkOutput("vadd vpend", 64'(dut.u_sb_vector.pending), 64'h4);
        checkOutput("vadd spend", 64'(dut.u_sb_scalar.pending), 64'd0);
        applyStimulus(1'b0, 32'h0, 36'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd2);
        tick();
        idle(1'b1);
        checkOutput("vadd cleared", 64'(dut.u_sb_vector.pending), 64'd0);

        // Undefined opcode issues as nop with a one-cycle illegal pulse.
        applyStimulus(1'b1, mk(7'h7F, 5'd12, 5'd13, 5'd14), 36'h700, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("illegal before", 64'(illegal), 64'd0);
        tick();
        idle(1'b1);
        checkOutput("illegal pulse", 64'(illegal), 64'd1);
        checkOutput("illegal ev", 64'(ex_valid), 64'd1);
        checkOutput("illegal nop", 64'(ex_ctrl), 64'd0);
        tick();
        idle(1'b1);
        checkOutput("illegal after", 64'(illegal), 64'd0);
        checkOutput("illegal pending", 64'(dut.u_sb_scalar.pending), 64'd0);

        // Halt drains pending r4, then stays halted until reset.
        applyStimulus(1'b1, mk(OP_ADD, 5'd4, 5'd20, 5'd21), 36'h800, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b1, mk(OP_HALT, 5'd0, 5'd0, 5'd0), 36'h804, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle(1'b1);
        checkOutput("halt ev", 64'(ex_valid), 64'd1);
        checkOutput("halt ctrl", 64'(ex_ctrl.halt), 64'd1);
        tick();
        applyStimulus(1'b1, mk(OP_ADD, 5'd10, 5'd20, 5'd21), 36'h808, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("drain if_ready", 64'(if_ready), 64'd0);
        checkOutput("drain ev", 64'(ex_valid), 64'd0);
        checkOutput("drain halted", 64'(halted), 64'd0);
        checkOutput("drain state", 64'(dut.state), 64'(DRAIN));
        tick();
        applyStimulus(1'b0, 32'h0, 36'h0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0);
        checkOutput("drain wb cycle", 64'(halted), 64'd0);
        tick();
        idle(1'b1);
        checkOutput("halted set", 64'(halted), 64'd1);
        checkOutput("halted if_ready", 64'(if_ready), 64'd0);
        tick();
        idle(1'b1);
        checkOutput("halted sticky", 64'(halted), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(1'b1);
        checkOutput("rst halted", 64'(halted), 64'd0);
        checkOutput("rst state", 64'(dut.state), 64'(RUN));
        checkOutput("rst if_ready", 64'(if_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
